// File: rtl/mispredict_event_monitor.sv
// Counts branch mispredicts, matches them against watch PCs and logs them
// into a show-ahead FIFO; a commit-stall watchdog runs alongside.
module mispredict_event_monitor #(
  parameter int NUM_WATCH   = 4,
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 256,
  localparam int HIT_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        log_all,
  input  logic                        mispredict,
  input  logic [PC_W-1:0]             mispredict_pc,
  input  logic [NUM_WATCH-1:0]        watch_en,
  input  logic [NUM_WATCH*PC_W-1:0]   watch_pc,
  input  logic [NUM_WATCH*DATA_W-1:0] watch_data,
  input  logic                        commit_valid,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [CNT_W-1:0]            rd_seq,
  output logic [PC_W-1:0]             rd_pc,
  output logic                        rd_hit,
  output logic [HIT_W-1:0]            rd_hit_idx,
  output logic [DATA_W-1:0]           rd_data,
  output logic [CW-1:0]               fifo_count,
  output logic [CNT_W-1:0]            mispredict_count,
  output logic [CNT_W-1:0]            dropped_count,
  output logic                        overflow,
  output logic                        stall_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0]    FULL_N  = CW'(DEPTH);
  localparam logic [SW-1:0]    LIM     = SW'(STALL_LIMIT);
  localparam logic [SW-1:0]    LIM_M1  = SW'(STALL_LIMIT - 1);

  typedef struct packed {
    logic [CNT_W-1:0]  seq;
    logic [PC_W-1:0]   pc;
    logic              hit;
    logic [HIT_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  mis_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              ovf;
  logic [SW-1:0]     stall_cnt;
  logic              stall;

  logic              hit;
  logic [HIT_W-1:0]  hit_idx;
  logic [DATA_W-1:0] hit_data;
  logic              full;
  logic              logged;
  logic              pop;
  logic              push;
  logic              drop;

  // Descending scan so the lowest matching comparator is written last
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      if (watch_en[i] && watch_pc[i*PC_W +: PC_W] == mispredict_pc) begin
        hit      = 1'b1;
        hit_idx  = HIT_W'(i);
        hit_data = watch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    full   = (count == FULL_N);
    logged = mispredict && (log_all || hit) && !clear;
    pop    = rd_valid && rd_ready && !clear;
    push   = logged && (!full || pop);
    drop   = logged && full && !pop;
  end

  always_comb begin
    new_entry.seq  = (mis_cnt == CNT_MAX) ? CNT_MAX : mis_cnt + 1'b1;
    new_entry.pc   = mispredict_pc;
    new_entry.hit  = hit;
    new_entry.idx  = hit_idx;
    new_entry.data = hit_data;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      mis_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (mispredict && mis_cnt != CNT_MAX) mis_cnt <= mis_cnt + 1'b1;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  // A commit in the limit cycle wins, so the flag never sets that edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (clear) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else if (commit_valid) begin
      stall_cnt <= '0;
    end else if (stall_cnt != LIM) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == LIM_M1) stall <= 1'b1;
    end
  end

  // Empty FIFO presents zeros so unwritten storage never leaks out
  assign head             = mem[rd_ptr];
  assign rd_valid         = (count != '0);
  assign rd_seq           = rd_valid ? head.seq  : '0;
  assign rd_pc            = rd_valid ? head.pc   : '0;
  assign rd_hit           = rd_valid ? head.hit  : 1'b0;
  assign rd_hit_idx       = rd_valid ? head.idx  : '0;
  assign rd_data          = rd_valid ? head.data : '0;
  assign fifo_count       = count;
  assign mispredict_count = mis_cnt;
  assign dropped_count    = drop_cnt;
  assign overflow         = ovf;
  assign stall_flag       = stall;

endmodule

// File: doc/mispredict_event_monitor.md
# mispredict_event_monitor

Synthesisable debug monitor that sits beside the out-of-order core, next to the branch unit's `mispredict`/`mispredict_pc` outputs and the ROB commit port. It counts mispredicts and matches each one against a programmable set of watch PCs. Each mispredict can carry a snapshot of a caller-supplied register value, and it is logged into a show-ahead FIFO. A commit-stall watchdog runs alongside. It replaces per-PC `$display` debugging with hardware that runs on FPGA and in regression.

## Interface
Parameters:
- `NUM_WATCH`, 4: number of watch-PC comparators (1..8).
- `PC_W`, 32: PC width.
- `DATA_W`, 32: snapshot data width.
- `DEPTH`, 16: log FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the mispredict and drop counters.
- `STALL_LIMIT`, 256: commit-free cycles before the stall flag sets; ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of all state; same effect as reset.
- `log_all`  in  1  1: log every mispredict. 0: log only watch hits.
- `mispredict`  in  1  one mispredict event this cycle.
- `mispredict_pc`  in  PC_W  PC of the mispredicting branch.
- `watch_en`  in  NUM_WATCH  per-comparator enable.
- `watch_pc`  in  NUM_WATCH*PC_W  watch PCs; comparator i is at slice [i*PC_W +: PC_W].
- `watch_data`  in  NUM_WATCH*DATA_W  snapshot value for comparator i, e.g. the PRF value of the mapped architectural register.
- `commit_valid`  in  1  the ROB retired at least one instruction this cycle.
- `rd_ready`  in  1  pop the FIFO head.
- `rd_valid`  out  1  FIFO not empty.
- `rd_seq`  out  CNT_W  head entry: event sequence number.
- `rd_pc`  out  PC_W  head entry: mispredict PC.
- `rd_hit`  out  1  head entry: a watch comparator matched.
- `rd_hit_idx`  out  $clog2(NUM_WATCH) (min 1)  head entry: index of the matching comparator.
- `rd_data`  out  DATA_W  head entry: snapshot data.
- `fifo_count`  out  $clog2(DEPTH)+1  number of valid entries.
- `mispredict_count`  out  CNT_W  total mispredicts; saturates.
- `dropped_count`  out  CNT_W  events lost to a full FIFO; saturates.
- `overflow`  out  1  sticky; set on the first drop.
- `stall_flag`  out  1  sticky; watchdog has fired.

## Operation
- **Match.** Comparator i hits when `watch_en[i]` is 1 and `watch_pc[i] == mispredict_pc`.
  - The lowest hitting index wins.
  - On a hit: hit=1, idx=i, data=`watch_data[i]` as sampled in the event cycle.
  - With no hit: hit=0, idx=0, data=0.
- **Count.** Every `mispredict` cycle increments `mispredict_count`, which saturates at 2^CNT_W−1. The count is independent of `log_all`.
- **Sequence number.** Each entry's seq is `mispredict_count`+1, computed before the increment. When saturated, seq = all-ones.
- **Log condition.** An event is logged when `mispredict` is 1 and either `log_all` is 1 or a comparator hits.
- **FIFO push and pop.**
  - A logged event pushes if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the event is dropped: `dropped_count` increments (saturating) and `overflow` sets.
- **Read port.** The FIFO is show-ahead: `rd_*` always present the head entry.
  - A pop occurs when `rd_valid` and `rd_ready` are both 1.
  - `rd_ready` while empty is ignored.
  - When empty, the `rd_*` data outputs are don't-care, but they must not be X after reset.
- **Pointers.** Read and write pointers wrap modulo DEPTH. `fifo_count` ranges 0..DEPTH.
- **Watchdog.**
  - A counter tracks cycles since the last `commit_valid`.
  - `commit_valid` zeroes the counter.
  - When the counter reaches STALL_LIMIT, `stall_flag` sets and the counter holds.
  - `stall_flag` clears only on `clear` or `reset`.
- **Clear.** `clear` empties the FIFO, zeroes every counter and flag, and takes priority over any same-cycle event, push or pop (that event is not counted).

## Timing
- **Reset values.** On `reset`=0, all outputs go to 0 asynchronously: `rd_valid`, `fifo_count`, both counters, both flags, and all `rd_*` data.
- **Latency.** An event in cycle N is visible after edge N: `mispredict_count` is updated and, if the FIFO was empty, `rd_valid`=1 with the new entry on `rd_*`.
- **Pop.** A pop at edge N advances the head after edge N.
- **Push and pop together.**
  - Both in the same cycle: `fifo_count` is unchanged.
  - Empty FIFO: a push and `rd_ready` in the same cycle do not pop, because `rd_valid` is 0 in that cycle.
- **Watchdog timing.** With no commits from reset release, `stall_flag` rises after the STALL_LIMIT-th edge. If `commit_valid` and the limit coincide in the same cycle, the counter clears and the flag does not set.
- **Reset mid-operation.** Entries are discarded and there is no partial state.

## Test plan
- **Watch hit.** `watch_pc[0]`=0x68 and `watch_pc[1]`=0x68, both enabled, `watch_data[0]`=0x0000_002A, `log_all`=0; one mispredict at 0x68 → one entry {seq 1, pc 0x68, hit 1, idx 0, data 0x2A}, `mispredict_count`=1.
- **Filtering.** `log_all`=0, mispredicts at 0x78 (no watch) then 0xB8 (watch idx 2) → `mispredict_count`=2, `fifo_count`=1, entry seq 2, idx 2.
- **Overflow.** DEPTH=16, `log_all`=1, 20 back-to-back mispredicts with no pops → `fifo_count`=16, `dropped_count`=4, `overflow`=1. Popping all entries returns seq 1..16 in order.
- **Full with simultaneous pop.** FIFO full, `rd_ready`=1 with a logged event in the same cycle → `fifo_count` stays 16, no drop, and the new tail entry is present.
- **Watchdog.** STALL_LIMIT=8:
  - `commit_valid` every 5 cycles → `stall_flag` stays 0.
  - Then no commits → `stall_flag`=1 after the 8th edge.
  - A later commit leaves it at 1.
  - `clear` → 0.
- **Reset and clear.** Assert `reset` low with 3 entries held → all outputs 0 immediately. `clear` in the same cycle as a mispredict → counters stay 0 and the FIFO stays empty.
